// File: rtl/airi5c_uart_tx_if.sv
// FIFO-to-transmitter handshake: the FIFO presents its head word and empty flag,
// and the transmitter answers with a one-cycle pop strobe.
interface airi5c_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_pop;

    modport master (
        output fifo_empty,
        output fifo_data,
        input  fifo_pop
    );

    modport slave (
        input  fifo_empty,
        input  fifo_data,
        output fifo_pop
    );
endinterface

// File: rtl/airi5c_uart_tx.sv
// UART transmit serializer: pops one byte per frame from the TX FIFO and shifts it
// out as start, 5-8 data bits LSB first, optional parity and 1 or 2 stop bits.
module airi5c_uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic [1:0]           data_bits,
    input  logic [1:0]           parity,
    input  logic                 stop_bits,
    airi5c_uart_tx_if.slave      fifo,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0]     LEN_OFFSET = IDX_W'(4);
    localparam logic [IDX_W-1:0]     IDX_ONE    = IDX_W'(1);
    localparam logic [DIV_WIDTH-1:0] CNT_ZERO   = DIV_WIDTH'(0);
    localparam logic [DIV_WIDTH-1:0] CNT_ONE    = DIV_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_r;
    logic [DIV_WIDTH-1:0]  cnt_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [IDX_W-1:0]      bit_idx_r;
    logic                  stop_idx_r;
    logic [1:0]            data_bits_r;
    logic                  par_en_r;
    logic                  par_bit_r;
    logic                  stop2_r;
    logic                  tx_r;
    logic                  busy_r;
    logic                  tx_done_r;

    logic                  bit_end_s;
    logic                  final_bit_s;
    logic                  final_cycle_s;
    logic                  pop_s;
    logic [IDX_W-1:0]      last_idx_s;

    // XOR of the low len+5 bits; bits above the frame length do not contribute.
    function automatic logic data_parity(input logic [DATA_WIDTH-1:0] d, input logic [1:0] len);
        logic p;
        p = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i < int'(len) + 32'sd5) begin
                p = p ^ d[i];
            end else begin
                p = p;
            end
        end
        return p;
    endfunction

    // Bit-boundary decode and the FIFO pop strobe.
    always_comb begin
        bit_end_s     = (cnt_r == CNT_ZERO);
        final_bit_s   = (stop_idx_r == stop2_r);
        last_idx_s    = IDX_W'(data_bits_r) + LEN_OFFSET;
        final_cycle_s = (state_r == STOP) && final_bit_s && bit_end_s;
        if (n_reset && ((state_r == IDLE) || final_cycle_s) && enable && !fifo.fifo_empty) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    assign fifo.fifo_pop = pop_s;
    assign tx            = tx_r;
    assign busy          = busy_r;
    assign tx_done       = tx_done_r;

    // Frame FSM; tx_done is raised one edge early so it lands on the final frame cycle.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            shift_r     <= {DATA_WIDTH{1'b0}};
            bit_idx_r   <= {IDX_W{1'b0}};
            stop_idx_r  <= 1'b0;
            data_bits_r <= 2'b00;
            par_en_r    <= 1'b0;
            par_bit_r   <= 1'b0;
            stop2_r     <= 1'b0;
            tx_r        <= 1'b1;
            busy_r      <= 1'b0;
            tx_done_r   <= 1'b0;
        end else begin
            tx_done_r <= 1'b0;
            if (pop_s) begin
                shift_r     <= fifo.fifo_data;
                data_bits_r <= data_bits;
                par_en_r    <= (parity == 2'b01) || (parity == 2'b10);
                par_bit_r   <= data_parity(fifo.fifo_data, data_bits) ^ (parity == 2'b10);
                stop2_r     <= stop_bits;
                cnt_r       <= baud_div;
                bit_idx_r   <= {IDX_W{1'b0}};
                stop_idx_r  <= 1'b0;
                state_r     <= START;
                tx_r        <= 1'b0;
                busy_r      <= 1'b1;
            end else begin
                case (state_r)
                    IDLE: begin
                        tx_r   <= 1'b1;
                        busy_r <= 1'b0;
                    end
                    START: begin
                        if (bit_end_s) begin
                            state_r   <= DATA;
                            tx_r      <= shift_r[0];
                            cnt_r     <= baud_div;
                            bit_idx_r <= {IDX_W{1'b0}};
                        end else begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end
                    end
                    DATA: begin
                        if (bit_end_s) begin
                            cnt_r <= baud_div;
                            if (bit_idx_r == last_idx_s) begin
                                if (par_en_r) begin
                                    state_r <= PARITY;
                                    tx_r    <= par_bit_r;
                                end else begin
                                    state_r    <= STOP;
                                    tx_r       <= 1'b1;
                                    stop_idx_r <= 1'b0;
                                    tx_done_r  <= !stop2_r && (baud_div == CNT_ZERO);
                                end
                            end else begin
                                shift_r   <= shift_r >> 1;
                                tx_r      <= shift_r[1];
                                bit_idx_r <= bit_idx_r + IDX_ONE;
                            end
                        end else begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end
                    end
                    PARITY: begin
                        if (bit_end_s) begin
                            state_r    <= STOP;
                            tx_r       <= 1'b1;
                            cnt_r      <= baud_div;
                            stop_idx_r <= 1'b0;
                            tx_done_r  <= !stop2_r && (baud_div == CNT_ZERO);
                        end else begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end
                    end
                    STOP: begin
                        if (bit_end_s) begin
                            if (!final_bit_s) begin
                                stop_idx_r <= 1'b1;
                                cnt_r      <= baud_div;
                                tx_done_r  <= (baud_div == CNT_ZERO);
                            end else begin
                                state_r <= IDLE;
                                tx_r    <= 1'b1;
                                busy_r  <= 1'b0;
                            end
                        end else begin
                            cnt_r     <= cnt_r - CNT_ONE;
                            tx_done_r <= final_bit_s && (cnt_r == CNT_ONE);
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        tx_r    <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/airi5c_uart_tx.md
Name: airi5c_uart_tx

Overview:
UART transmit serializer that sits directly downstream of the TX FIFO in the UART peripheral. It pops one byte per frame from the FIFO and shifts it out on the tx line as start bit, 5-8 data bits (LSB first), optional parity bit and 1 or 2 stop bits. Bit timing comes from a programmable clocks-per-bit divisor. Frame configuration comes from the UART control register.

Parameters:
DATA_WIDTH, 8, width of fifo_data and of the shift register; the maximum frame data length.
DIV_WIDTH, 16, width of the baud divisor input.

Ports:
clk  input  1  system clock; all logic on rising edge.
n_reset  input  1  asynchronous, active-low reset.
enable  input  1  transmitter enable; gates the start of new frames only.
baud_div  input  DIV_WIDTH  clocks per bit minus 1.
data_bits  input  2  data length: 00=5, 01=6, 10=7, 11=8.
parity  input  2  parity mode: 00=none, 01=even, 10=odd, 11=none.
stop_bits  input  1  stop bits: 0=one, 1=two.
fifo_empty  input  1  TX FIFO empty flag.
fifo_data  input  DATA_WIDTH  FIFO head word; valid combinationally while fifo_empty=0.
fifo_pop  output  1  single-cycle pop strobe to the FIFO.
tx  output  1  serial line, registered; idle high.
busy  output  1  high from the pop cycle until the last stop-bit cycle completes.
tx_done  output  1  one-cycle pulse in the final clock of each frame.

Behaviour:
- Reset (async): tx=1, fifo_pop=0, busy=0, tx_done=0, state=IDLE, counters and shift register=0. A reset asserted mid-frame aborts the frame immediately; the popped byte is lost.
- States: IDLE, START, DATA, PARITY, STOP.
- Pop rule: fifo_pop is combinational, =1 only when (state==IDLE, or last cycle of the final stop bit) && enable && !fifo_empty. In the pop cycle, fifo_data is latched into the shift register. data_bits, parity and stop_bits are latched into frame-config registers. The FIFO clears the entry on pop, so data must be captured that same edge.
- Latency: tx goes low 1 cycle after the pop cycle; the START state begins at the next edge.
- Bit timing: a down-counter is loaded with baud_div at each bit start. Each bit lasts baud_div+1 cycles. baud_div=0 gives 1 cycle per bit. baud_div changes mid-frame take effect at the next bit boundary.
- START: tx=0 for one bit period, then DATA.
- DATA: tx=shift_reg[0]; shift right at each bit end. After N bits (N = latched length), go to PARITY if parity is even or odd, otherwise STOP.
- PARITY: tx = XOR of the N transmitted data bits for even, its inverse for odd. Bits above N are ignored.
- STOP: tx=1 for 1 or 2 bit periods. In the final cycle, tx_done=1. Then:
  - if the pop condition holds, pop and go directly to START (back-to-back, no idle gap);
  - otherwise go to IDLE.
- enable low mid-frame: the current frame completes normally; no further pop occurs.
- Config-input changes mid-frame: they do not affect the frame in progress.
- Frame length: 1+N+P+S bit periods, where P is 0 or 1 and S is 1 or 2.

Test Plan:
- baud_div=3, 8N1, FIFO holds 0x55 -> one fifo_pop pulse; tx pattern 0,1,0,1,0,1,0,1,0,1 with each level held 4 cycles (40 cycles total); tx_done on cycle 40; busy falls afterwards; tx stays 1.
- baud_div=1, 7 data bits, even parity, 2 stop bits (7E2), byte 0x41 -> tx bits 0 | 1,0,0,0,0,0,1 | 0 | 1,1, each bit held 2 cycles.
- Same 7-bit setup with odd parity, byte 0xC1 -> bit 7 ignored; parity bit=1.
- Two bytes 0xA5 and 0x3C queued, baud_div=0, 8N1 -> second fifo_pop occurs in the last stop cycle of frame 1; start bit of frame 2 follows with no idle cycle; 20 bits total.
- n_reset pulsed low during the DATA state of byte 0xFF -> tx=1 and busy=0 asynchronously. After release, IDLE; the next queued byte transmits correctly.
- enable dropped during the PARITY bit with 3 bytes queued -> current frame finishes; no pop while enable=0; transmission resumes 1 cycle after enable returns high.
